fnd_display_arbiter: RTL and testbench
======================================

FND_DISPLAY_ARBITER -- requirements
Module: fnd_display_arbiter

Interface
REQ-001 Parameter DWELL_CYCLES, default 100_000_000, minimum clock cycles a granted source owns the display (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 i_clk  input  1  single system clock; all logic rising-edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  2  display request per source; bit n = source n.
REQ-005 i_data0  input  14  source 0 display value (binary, 0..16383).
REQ-006 i_data1  input  14  source 1 display value (binary, 0..16383).
REQ-007 o_grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-008 o_counter_data  output  14  registered value driven to the FND controller counter-data input.
REQ-009 o_busy  output  1  high while in HOLD0 or HOLD1.

Function
REQ-010 State machine SHALL have exactly three states: IDLE, HOLD0, HOLD1.
REQ-011 IDLE: no request -> stay; one request -> HOLD of that source; both -> HOLD of source not last granted (round-robin pointer; pointer = source 0 after reset).
REQ-012 o_grant, o_busy and state SHALL change one cycle after the sampled i_req (registered grant).
REQ-013 In HOLDn, o_counter_data SHALL follow i_datan with exactly one cycle latency, every cycle.
REQ-014 Dwell counter SHALL clear on entry to any HOLD and expire when it equals DWELL_CYCLES-1.
REQ-015 Dropping own request mid-dwell SHALL NOT end the hold early; the dwell always completes.
REQ-016 Other request mid-dwell SHALL be ignored until expiry.
REQ-017 At expiry: other source requesting -> switch directly to its HOLD (no IDLE cycle); else own request active -> stay, counter restarts; else -> IDLE.
REQ-018 Round-robin pointer SHALL update to the granted source on every HOLD entry.
REQ-019 In IDLE, o_counter_data SHALL hold the last displayed value.
REQ-020 Dwell counter SHALL be 27 bits and SHALL never wrap within a hold.

Reset
REQ-021 While i_reset is high at a clock edge: state IDLE, o_grant 2'b00, o_busy 0, o_counter_data 0, dwell counter 0, pointer = source 0.
REQ-022 Reset asserted mid-hold SHALL abort the hold; first grant after reset follows REQ-011 with the reset pointer.

Configuration
REQ-023 Macro FND_ARB_SATURATE_EN defined: o_counter_data SHALL clamp source values above 9999 to 9999.
REQ-024 Macro FND_ARB_SATURATE_EN undefined: source values SHALL pass unmodified, including 10000..16383.

Structure
REQ-025 Shared package fnd_pkg SHALL hold the state enum type, FND_DATA_W = 14 and FND_MAX_VALUE = 9999.
REQ-026 Dwell counter SHALL be a sub-module fnd_dwell_timer (inputs clear/enable, output expire).
REQ-027 Block SHALL be instantiable directly in front of the FND controller with no glue logic.

Verification (DWELL_CYCLES = 4)
REQ-028 Reset, i_req=00 -> o_grant=00, o_busy=0, o_counter_data=0 held indefinitely.
REQ-029 i_req=01, i_data0=1234 -> next cycle o_grant=01, o_busy=1, following cycle o_counter_data=1234; drop i_req after 1 cycle -> hold lasts 4 cycles, then IDLE with 1234 retained.
REQ-030 i_req=11 from reset -> HOLD1 first (pointer at source 0), after 4 cycles HOLD0, then alternation every 4 cycles with no IDLE cycle.
REQ-031 HOLD0 active, i_req=01 steady -> hold re-arms every 4 cycles, o_grant stays 01.
REQ-032 i_data0=12000: with FND_ARB_SATURATE_EN -> o_counter_data=9999; without -> 12000.
REQ-033 Reset asserted at cycle 2 of HOLD1 -> next cycle all outputs at reset values; i_req=11 afterward -> HOLD1 granted.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND display arbiter.
// Holds the arbiter state enum, the data width and the 4-digit display clamp.
package fnd_pkg;

    localparam int FND_DATA_W = 14;
    localparam logic [FND_DATA_W-1:0] FND_MAX_VALUE = 14'd9999;
    localparam int FND_DWELL_W = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD0 = 2'd1,
        ST_HOLD1 = 2'd2
    } fnd_state_e;

    function automatic logic [FND_DATA_W-1:0] fnd_clamp(input logic [FND_DATA_W-1:0] v);
        return (v > FND_MAX_VALUE) ? FND_MAX_VALUE : v;
    endfunction

endpackage

// File: rtl/fnd_dwell_timer.sv
// Dwell timer: counts owned cycles and flags the last one of a dwell period.
// Clear has priority over enable so a re-armed hold starts from zero.
module fnd_dwell_timer
    import fnd_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [FND_DWELL_W-1:0] LAST = FND_DWELL_W'(DWELL_CYCLES - 1);

    logic [FND_DWELL_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expire_o = (count_q == LAST);

endmodule

// File: rtl/fnd_display_arbiter.sv
// Two-source round-robin arbiter with a minimum dwell time for a 4-digit FND.
// Optional macro FND_ARB_SATURATE_EN clamps displayed values above 9999.
module fnd_display_arbiter
    import fnd_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_req,
    input  logic [FND_DATA_W-1:0] i_data0,
    input  logic [FND_DATA_W-1:0] i_data1,
    output logic [1:0]            o_grant,
    output logic [FND_DATA_W-1:0] o_counter_data,
    output logic                  o_busy
);

    fnd_state_e            state_q, state_d;
    logic                  rr_q, rr_d;
    logic [FND_DATA_W-1:0] data_q, data_d;
    logic [FND_DATA_W-1:0] src_data;
    logic                  expire;
    logic                  busy;

    // Counter is held at zero while idle and restarts at every expiry,
    // so each hold (fresh or re-armed) sees a full dwell period.
    fnd_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .clk_i    (i_clk),
        .rst_i    (i_reset),
        .clear_i  ((state_q == ST_IDLE) || expire),
        .enable_i (busy),
        .expire_o (expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req == 2'b11)
                    state_d = rr_q ? ST_HOLD0 : ST_HOLD1;
                else if (i_req[0])
                    state_d = ST_HOLD0;
                else if (i_req[1])
                    state_d = ST_HOLD1;
            end
            ST_HOLD0: begin
                if (expire)
                    state_d = i_req[1] ? ST_HOLD1 : (i_req[0] ? ST_HOLD0 : ST_IDLE);
            end
            ST_HOLD1: begin
                if (expire)
                    state_d = i_req[0] ? ST_HOLD0 : (i_req[1] ? ST_HOLD1 : ST_IDLE);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (state_d == ST_HOLD0)
            rr_d = 1'b0;
        else if (state_d == ST_HOLD1)
            rr_d = 1'b1;
    end

    always_comb begin
        o_grant = 2'b00;
        busy    = 1'b0;
        case (state_q)
            ST_HOLD0: begin o_grant = 2'b01; busy = 1'b1; end
            ST_HOLD1: begin o_grant = 2'b10; busy = 1'b1; end
            default:  begin o_grant = 2'b00; busy = 1'b0; end
        endcase
    end

    assign src_data = (state_q == ST_HOLD1) ? i_data1 : i_data0;

    always_comb begin
        data_d = data_q;
        if (busy) begin
`ifdef FND_ARB_SATURATE_EN
            data_d = fnd_clamp(src_data);
`else
            data_d = src_data;
`endif
        end
    end

    assign o_busy         = busy;
    assign o_counter_data = data_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter with DWELL_CYCLES = 4.
module tb_fnd_display_arbiter;
    import fnd_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req;
    logic [FND_DATA_W-1:0] d0, d1;
    logic [1:0]            grant;
    logic [FND_DATA_W-1:0] cdata;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    fnd_display_arbiter #(.DWELL_CYCLES(4)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_req          (req),
        .i_data0        (d0),
        .i_data1        (d1),
        .o_grant        (grant),
        .o_counter_data (cdata),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; d0 = 14'd111; d1 = 14'd222;
        tick();
        tick();
        if (grant !== 2'b00 || busy !== 1'b0 || cdata !== 14'd0) begin
            failures++;
            $display("FAIL reset_active got g=%b b=%b d=%0d exp g=00 b=0 d=0", grant, busy, cdata);
        end
        checks++;
        rst = 1'b0; req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (grant !== 2'b00 || busy !== 1'b0 || cdata !== 14'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got g=%b b=%b d=%0d exp g=00 b=0 d=0", k, grant, busy, cdata);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        req = 2'b01; d0 = 14'd1234;
        tick();
        if (grant !== 2'b01 || busy !== 1'b1 || cdata !== 14'd0) begin
            failures++;
            $display("FAIL single_grant got g=%b b=%b d=%0d exp g=01 b=1 d=0", grant, busy, cdata);
        end
        checks++;
        req = 2'b00;
        for (int k = 2; k <= 4; k++) begin
            tick();
            if (grant !== 2'b01 || cdata !== 14'd1234) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got g=%b d=%0d exp g=01 d=1234", k, grant, cdata);
            end
            checks++;
        end
        tick();
        if (grant !== 2'b00 || busy !== 1'b0 || cdata !== 14'd1234) begin
            failures++;
            $display("FAIL single_idle got g=%b b=%b d=%0d exp g=00 b=0 d=1234", grant, busy, cdata);
        end
        checks++;
        d0 = 14'd5555;
        tick();
        tick();
        if (cdata !== 14'd1234) begin
            failures++;
            $display("FAIL idle_retain got=%0d exp=1234", cdata);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [1:0]            eg;
        logic [FND_DATA_W-1:0] ed;
        do_reset();
        req = 2'b11; d0 = 14'd111; d1 = 14'd222;
        for (int k = 1; k <= 12; k++) begin
            tick();
            eg = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
            if (grant !== eg || busy !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant cyc=%0d got g=%b b=%b exp g=%b b=1", k, grant, busy, eg);
            end
            checks++;
            // data reflects the owner of the previous cycle
            if (k >= 2) begin
                ed = (((k - 2) / 4) % 2 == 0) ? 14'd222 : 14'd111;
                if (cdata !== ed) begin
                    failures++;
                    $display("FAIL rr_data cyc=%0d got=%0d exp=%0d", k, cdata, ed);
                end
                checks++;
            end
        end
    endtask

    task automatic test_rearm();
        do_reset();
        req = 2'b01; d0 = 14'd77;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (grant !== 2'b01 || busy !== 1'b1) begin
                failures++;
                $display("FAIL rearm_grant cyc=%0d got g=%b b=%b exp g=01 b=1", k, grant, busy);
            end
            checks++;
        end
        if (cdata !== 14'd77) begin
            failures++;
            $display("FAIL rearm_data got=%0d exp=77", cdata);
        end
        checks++;
    endtask

    task automatic test_ignore_other();
        do_reset();
        req = 2'b01; d0 = 14'd5; d1 = 14'd9;
        tick();
        tick();
        req = 2'b11;
        tick();
        tick();
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL ignore_other got=%b exp=01", grant);
        end
        checks++;
        tick();
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL switch_no_idle got=%b exp=10", grant);
        end
        checks++;
        req = 2'b00;
        tick(); tick(); tick();
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL hold1_full got=%b exp=10", grant);
        end
        checks++;
        tick();
        if (grant !== 2'b00 || cdata !== 14'd9) begin
            failures++;
            $display("FAIL hold1_idle got g=%b d=%0d exp g=00 d=9", grant, cdata);
        end
        checks++;
    endtask

    task automatic test_saturate();
        logic [FND_DATA_W-1:0] e12000, e10000;
`ifdef FND_ARB_SATURATE_EN
        e12000 = 14'd9999; e10000 = 14'd9999;
`else
        e12000 = 14'd12000; e10000 = 14'd10000;
`endif
        do_reset();
        req = 2'b01; d0 = 14'd12000;
        tick();
        tick();
        if (cdata !== e12000) begin
            failures++;
            $display("FAIL sat_12000 got=%0d exp=%0d", cdata, e12000);
        end
        checks++;
        d0 = 14'd9999;
        tick();
        if (cdata !== 14'd9999) begin
            failures++;
            $display("FAIL sat_9999 got=%0d exp=9999", cdata);
        end
        checks++;
        d0 = 14'd10000;
        tick();
        if (cdata !== e10000) begin
            failures++;
            $display("FAIL sat_10000 got=%0d exp=%0d", cdata, e10000);
        end
        checks++;
        d0 = 14'd16383;
        tick();
        if (cdata !== ((e10000 == 14'd9999) ? 14'd9999 : 14'd16383)) begin
            failures++;
            $display("FAIL sat_16383 got=%0d", cdata);
        end
        checks++;
        req = 2'b00;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 2'b11; d0 = 14'd300; d1 = 14'd400;
        tick();
        tick();
        if (grant !== 2'b10 || cdata !== 14'd400) begin
            failures++;
            $display("FAIL mid_pre got g=%b d=%0d exp g=10 d=400", grant, cdata);
        end
        checks++;
        rst = 1'b1;
        tick();
        if (grant !== 2'b00 || busy !== 1'b0 || cdata !== 14'd0) begin
            failures++;
            $display("FAIL mid_reset got g=%b b=%b d=%0d exp g=00 b=0 d=0", grant, busy, cdata);
        end
        checks++;
        rst = 1'b0;
        tick();
        if (grant !== 2'b10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_regrant got g=%b b=%b exp g=10 b=1", grant, busy);
        end
        checks++;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; d0 = '0; d1 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_rearm();
        test_ignore_other();
        test_saturate();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
